// File: rtl/bus2_pkg.sv
// Shared bus-2 definitions: command codes, controller states and
// geometry helpers used by the parametrised memory controller.
package bus2_pkg;

  localparam int unsigned CTR2_W = 3;

  typedef enum logic [CTR2_W-1:0] {
    C2_NOP          = 3'd0,
    C2_RESPONSE     = 3'd1,
    C2_READ_LINE    = 3'd2,
    C2_WRITE_LINE   = 3'd3,
    C2_WRITE_MASKED = 3'd4
  } c2_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_XFER = 3'd2,
    ST_WR_XFER = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  // Number of data beats in one cache line.
  function automatic int unsigned calc_beats(int unsigned data_w, int unsigned line_bytes);
    return line_bytes / (data_w / 8);
  endfunction

  // Width of the line address carried on A2.
  function automatic int unsigned calc_a2_w(int unsigned mem_bytes, int unsigned line_bytes);
    return $clog2(mem_bytes) - $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/mem_ctr_param_if.sv
// Bus-2 signal bundle between the cache side (master) and the memory
// controller (slave).
interface mem_ctr_param_if
  import bus2_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned MEM_BYTES  = 1024
);

  localparam int unsigned BYTES_PER_BEAT = DATA_W / 8;
  localparam int unsigned A2_W           = calc_a2_w(MEM_BYTES, LINE_BYTES);

  logic [A2_W-1:0]           A2_IN;
  logic [CTR2_W-1:0]         C2_IN;
  logic [CTR2_W-1:0]         C2_OUT;
  logic                      C2_OE;
  logic [DATA_W-1:0]         D2_IN;
  logic [BYTES_PER_BEAT-1:0] BE2_IN;
  logic [DATA_W-1:0]         D2_OUT;
  logic                      D2_OE;
  logic                      BUSY;

  modport master (
    output A2_IN, C2_IN, D2_IN, BE2_IN,
    input  C2_OUT, C2_OE, D2_OUT, D2_OE, BUSY
  );

  modport slave (
    input  A2_IN, C2_IN, D2_IN, BE2_IN,
    output C2_OUT, C2_OE, D2_OUT, D2_OE, BUSY
  );

endinterface

// File: rtl/mem_ctr_ram.sv
// Byte-organised backing store with one beat-wide asynchronous read port and
// one beat-wide write port with per-byte enables; contents are never reset.
module mem_ctr_ram #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic                                          clk,
  input  logic [DATA_W/8-1:0]                           we_i,
  input  logic [$clog2(MEM_BYTES/(DATA_W/8))-1:0]       waddr_i,
  input  logic [DATA_W-1:0]                             wdata_i,
  input  logic [$clog2(MEM_BYTES/(DATA_W/8))-1:0]       raddr_i,
  output logic [DATA_W-1:0]                             rdata_o
);

  localparam int unsigned BPB     = DATA_W / 8;
  localparam int unsigned SUB_W   = $clog2(BPB);
  localparam int unsigned BYTE_AW = $clog2(MEM_BYTES);

  logic [7:0] mem_q [MEM_BYTES];

  // Byte j of a beat lives at beat_index*BPB + j (little-endian within the beat).
  always_ff @(posedge clk) begin
    for (int j = 0; j < BPB; j++) begin
      if (we_i[j]) begin
        mem_q[(BYTE_AW'(waddr_i) << SUB_W) | BYTE_AW'(j)] <= wdata_i[8*j +: 8];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int j = 0; j < BPB; j++) begin
      rdata_o[8*j +: 8] = mem_q[(BYTE_AW'(raddr_i) << SUB_W) | BYTE_AW'(j)];
    end
  end

endmodule

// File: rtl/mem_ctr_param.sv
// Bus-2 memory controller: accepts line read/write commands while idle and
// answers after a fixed LATENCY, with byte-masked writes and explicit bus enables.
module mem_ctr_param
  import bus2_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned MEM_BYTES  = 1024,
  parameter int unsigned LATENCY    = 100
) (
  input  logic           CLK,
  input  logic           RESET,
  mem_ctr_param_if.slave bus
);

  localparam int unsigned BPB    = DATA_W / 8;
  localparam int unsigned BEATS  = calc_beats(DATA_W, LINE_BYTES);
  localparam int unsigned A2_W   = calc_a2_w(MEM_BYTES, LINE_BYTES);
  localparam int unsigned LB_W   = $clog2(BEATS);
  localparam int unsigned BIDX_W = (BEATS > 1) ? LB_W : 1;
  localparam int unsigned RAM_AW = A2_W + LB_W;
  localparam int unsigned CNT_W  = $clog2(LATENCY + 1);

  if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_data_w
    $error("mem_ctr_param: DATA_W must be a non-zero multiple of 8");
  end
  if ((LINE_BYTES % BPB) != 0 || LINE_BYTES < BPB) begin : g_bad_line
    $error("mem_ctr_param: LINE_BYTES must be a multiple of DATA_W/8");
  end
  if (LATENCY < BEATS + 1) begin : g_bad_latency
    $error("mem_ctr_param: LATENCY must be at least BEATS+1");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIDX_W-1:0]   beat_q, beat_d;
  logic [A2_W-1:0]     line_q, line_d;
  logic                masked_q, masked_d;

  logic                c2_oe_q, c2_oe_d;
  logic [CTR2_W-1:0]   c2_out_q, c2_out_d;
  logic                d2_oe_q, d2_oe_d;
  logic [DATA_W-1:0]   d2_out_q, d2_out_d;
  logic                busy_q, busy_d;

  logic                acc_rd_c, acc_wr_c, acc_mask_c;
  logic [BPB-1:0]      ram_we_c;
  logic [RAM_AW-1:0]   ram_waddr_c, ram_raddr_c;
  logic [DATA_W-1:0]   ram_rdata_c;

  // Beat index inside the whole memory: line number above, beat-in-line below.
  function automatic logic [RAM_AW-1:0] beat_addr(logic [A2_W-1:0] line, logic [BIDX_W-1:0] beat);
    return (RAM_AW'(line) << LB_W) | RAM_AW'(beat);
  endfunction

  assign acc_rd_c   = (state_q == ST_IDLE) && (bus.C2_IN == C2_READ_LINE);
  assign acc_mask_c = (state_q == ST_IDLE) && (bus.C2_IN == C2_WRITE_MASKED);
  assign acc_wr_c   = acc_mask_c || ((state_q == ST_IDLE) && (bus.C2_IN == C2_WRITE_LINE));

  // State, counters and registered bus outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      beat_q   <= '0;
      line_q   <= '0;
      masked_q <= 1'b0;
      c2_oe_q  <= 1'b0;
      c2_out_q <= C2_NOP;
      d2_oe_q  <= 1'b0;
      d2_out_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      line_q   <= line_d;
      masked_q <= masked_d;
      c2_oe_q  <= c2_oe_d;
      c2_out_q <= c2_out_d;
      d2_oe_q  <= d2_oe_d;
      d2_out_q <= d2_out_d;
      busy_q   <= busy_d;
    end
  end

  // cnt_q holds the cycle number relative to command acceptance, saturating at LATENCY.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    line_d   = line_q;
    masked_d = masked_q;
    if (cnt_q != CNT_W'(LATENCY)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        beat_d = '0;
        if (acc_rd_c) begin
          state_d = ST_RD_WAIT;
          cnt_d   = CNT_W'(1);
          line_d  = bus.A2_IN;
        end else if (acc_wr_c) begin
          state_d  = (BEATS > 1) ? ST_WR_XFER : ST_WR_WAIT;
          cnt_d    = CNT_W'(1);
          beat_d   = (BEATS > 1) ? BIDX_W'(1) : '0;
          line_d   = bus.A2_IN;
          masked_d = acc_mask_c;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          state_d = ST_RD_XFER;
          beat_d  = '0;
        end
      end
      ST_RD_XFER: begin
        if (beat_q == BIDX_W'(BEATS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BIDX_W'(1);
        end
      end
      ST_WR_XFER: begin
        if (beat_q == BIDX_W'(BEATS - 1)) begin
          state_d = ST_WR_WAIT;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BIDX_W'(1);
        end
      end
      ST_WR_WAIT: begin
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        beat_d  = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they appear registered in the cycle they describe.
  always_comb begin
    c2_oe_d     = (state_d != ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    c2_out_d    = C2_NOP;
    if (state_d == ST_RD_XFER || state_d == ST_RESP) begin
      c2_out_d = C2_RESPONSE;
    end
    d2_oe_d     = (state_d == ST_RD_XFER);
    ram_raddr_c = beat_addr(line_d, beat_d);
    d2_out_d    = d2_oe_d ? ram_rdata_c : '0;

    ram_we_c    = '0;
    ram_waddr_c = beat_addr(line_q, beat_q);
    if (acc_wr_c) begin
      ram_we_c    = acc_mask_c ? bus.BE2_IN : '1;
      ram_waddr_c = beat_addr(bus.A2_IN, '0);
    end else if (state_q == ST_WR_XFER) begin
      ram_we_c = masked_q ? bus.BE2_IN : '1;
    end
  end

  assign bus.C2_OE  = c2_oe_q;
  assign bus.C2_OUT = c2_out_q;
  assign bus.D2_OE  = d2_oe_q;
  assign bus.D2_OUT = d2_out_q;
  assign bus.BUSY   = busy_q;

  mem_ctr_ram #(
    .DATA_W    (DATA_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_ram (
    .clk     (CLK),
    .we_i    (ram_we_c),
    .waddr_i (ram_waddr_c),
    .wdata_i (bus.D2_IN),
    .raddr_i (ram_raddr_c),
    .rdata_o (ram_rdata_c)
  );

endmodule
